// File: rtl/simple_memory_lsu.sv
// simple_memory_lsu: single-outstanding load/store initiator for simple_memory.
// Accepts one byte/half/word access, checks alignment and bounds, drives the
// memory ports for exactly one ACCESS cycle and returns a one-cycle response.
module simple_memory_lsu #(
  parameter int unsigned pWords = 32'd44
) (
  input  logic        iwClk,
  input  logic        iwnRst,
  input  logic        iwReqValid,
  output logic        owReqReady,
  input  logic        iwReqWrite,
  input  logic [1:0]  iwReqSize,
  input  logic        iwReqSigned,
  input  logic [31:0] iwReqAddr,
  input  logic [31:0] iwReqWdata,
  output logic        owRespValid,
  output logic [31:0] owRespData,
  output logic        owRespFault,
  output logic [31:0] owReadAddr,
  output logic [31:0] owWriteAddr,
  output logic [31:0] owWriteData,
  output logic [3:0]  owWstrb,
  input  logic [31:0] iwReadData
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  // Byte count of the whole memory; the end-of-access compare is done in
  // 33 bits so an address near 2^32 wraps into a fault instead of passing.
  localparam logic [32:0] LIMIT = 33'(pWords) << 2;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] raddr_q, raddr_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdout_q, wdout_d;

  logic [32:0] req_nbytes;
  logic [32:0] req_end;
  logic        req_fault;
  logic [31:0] req_wmask;
  logic [3:0]  strb;
  logic [31:0] load_ext;

  // Request-side fault check and store-data masking, evaluated in IDLE.
  always_comb begin
    req_nbytes = 33'd4;
    req_wmask  = iwReqWdata;
    case (iwReqSize)
      2'b00: begin req_nbytes = 33'd1; req_wmask = {24'h0, iwReqWdata[7:0]};  end
      2'b01: begin req_nbytes = 33'd2; req_wmask = {16'h0, iwReqWdata[15:0]}; end
      default: ;
    endcase
    req_end   = {1'b0, iwReqAddr} + req_nbytes;
    req_fault = (iwReqSize == 2'b11)
             || (iwReqSize == 2'b01 && iwReqAddr[0])
             || (iwReqSize == 2'b10 && iwReqAddr[1:0] != 2'b00)
             || (req_end > LIMIT);
  end

  // Write strobe pattern and load extension from the latched access.
  always_comb begin
    strb     = 4'b0000;
    load_ext = rdata_q;
    case (size_q)
      2'b00: begin
        strb     = 4'b0001;
        load_ext = {{24{signed_q & rdata_q[7]}}, rdata_q[7:0]};
      end
      2'b01: begin
        strb     = 4'b0011;
        load_ext = {{16{signed_q & rdata_q[15]}}, rdata_q[15:0]};
      end
      2'b10: strb = 4'b1111;
      default: ;
    endcase
  end

  // Next-state and register-update logic for IDLE -> ACCESS -> RESP.
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    fault_d  = fault_q;
    rdata_d  = rdata_q;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    wdout_d  = wdout_q;
    case (state_q)
      IDLE: begin
        if (iwReqValid) begin
          write_d  = iwReqWrite;
          size_d   = iwReqSize;
          signed_d = iwReqSigned;
          fault_d  = req_fault;
          if (req_fault) begin
            state_d = RESP;
          end else begin
            state_d = ACCESS;
            // Memory ports only move for an access that will really happen.
            raddr_d = iwReqAddr;
            waddr_d = iwReqAddr;
            if (iwReqWrite) wdout_d = req_wmask;
          end
        end
      end
      ACCESS: begin
        // Memory sampled on the falling edge inside this cycle.
        if (!write_q) rdata_d = iwReadData;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      fault_q  <= 1'b0;
      rdata_q  <= 32'h0;
      raddr_q  <= 32'h0;
      waddr_q  <= 32'h0;
      wdout_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      wdout_q  <= wdout_d;
    end
  end

  // Outputs decode straight from state so reset clears the strobe at once.
  always_comb begin
    owReqReady  = (state_q == IDLE);
    owRespValid = (state_q == RESP);
    owRespFault = (state_q == RESP) && fault_q;
    owRespData  = ((state_q == RESP) && !write_q && !fault_q) ? load_ext : 32'h0;
    owWstrb     = ((state_q == ACCESS) && write_q) ? strb : 4'b0000;
    owReadAddr  = raddr_q;
    owWriteAddr = waddr_q;
    owWriteData = wdout_q;
  end

endmodule

// File: tb/tb_simple_memory_lsu.sv
// Directed bench for simple_memory_lsu with a falling-edge byte memory model.
module tb_simple_memory_lsu;

  localparam int PW   = 44;
  localparam int MEMB = PW * 4;

  logic        iwClk = 1'b0;
  logic        iwnRst = 1'b0;
  logic        iwReqValid = 1'b0;
  logic        owReqReady;
  logic        iwReqWrite = 1'b0;
  logic [1:0]  iwReqSize = 2'b00;
  logic        iwReqSigned = 1'b0;
  logic [31:0] iwReqAddr = 32'h0;
  logic [31:0] iwReqWdata = 32'h0;
  logic        owRespValid;
  logic [31:0] owRespData;
  logic        owRespFault;
  logic [31:0] owReadAddr;
  logic [31:0] owWriteAddr;
  logic [31:0] owWriteData;
  logic [3:0]  owWstrb;
  logic [31:0] iwReadData;

  simple_memory_lsu #(.pWords(PW)) dut (
    .iwClk(iwClk), .iwnRst(iwnRst),
    .iwReqValid(iwReqValid), .owReqReady(owReqReady),
    .iwReqWrite(iwReqWrite), .iwReqSize(iwReqSize), .iwReqSigned(iwReqSigned),
    .iwReqAddr(iwReqAddr), .iwReqWdata(iwReqWdata),
    .owRespValid(owRespValid), .owRespData(owRespData), .owRespFault(owRespFault),
    .owReadAddr(owReadAddr), .owWriteAddr(owWriteAddr), .owWriteData(owWriteData),
    .owWstrb(owWstrb), .iwReadData(iwReadData)
  );

  always #5 iwClk = ~iwClk;

  // Byte-addressed memory acting on the falling edge; addressed byte lands in [7:0].
  logic [7:0] mem [0:MEMB-1];
  logic       mem_clr = 1'b1;
  longint     wa, ra;
  always @(negedge iwClk) begin
    if (mem_clr) begin
      for (int i = 0; i < MEMB; i++) mem[i] <= 8'h00;
      iwReadData <= 32'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        wa = longint'(owWriteAddr) + longint'(i);
        if (owWstrb[i] && wa < MEMB) mem[wa[7:0]] <= owWriteData[8*i +: 8];
        ra = longint'(owReadAddr) + longint'(i);
        iwReadData[8*i +: 8] <= (ra < MEMB) ? mem[ra[7:0]] : 8'h00;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request from IDLE; reports response, latency in cycles and strobe activity.
  task automatic req(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic flt, output int lat,
                     output int nstrb, output logic [3:0] sb, output logic [31:0] wd);
    logic done;
    @(posedge iwClk); #1;
    chk("ready_idle", {31'h0, owReqReady}, 32'h1);
    iwReqValid = 1'b1; iwReqWrite = w; iwReqSize = sz; iwReqSigned = sg;
    iwReqAddr = a; iwReqWdata = d;
    @(posedge iwClk); #1;
    iwReqValid = 1'b0;
    lat = 0; nstrb = 0; sb = 4'h0; wd = 32'h0; rd = 32'hxxxxxxxx; flt = 1'bx;
    done = 1'b0;
    while (!done && lat < 6) begin
      @(negedge iwClk);
      lat++;
      if (owWstrb != 4'h0) begin nstrb++; sb = owWstrb; wd = owWriteData; end
      if (owRespValid) begin done = 1'b1; rd = owRespData; flt = owRespFault; end
    end
    chk("resp_seen", {31'h0, done}, 32'h1);
  endtask

  logic [31:0] rd, wd;
  logic        flt;
  logic [3:0]  sb;
  int          lat, ns;
  int          nacc, nresp, a1, a2, rv;

  initial begin
    // Reset state
    #12;
    chk("rst_ready", {31'h0, owReqReady}, 32'h1);
    chk("rst_rvalid", {31'h0, owRespValid}, 32'h0);
    chk("rst_fault", {31'h0, owRespFault}, 32'h0);
    chk("rst_rdata", owRespData, 32'h0);
    chk("rst_raddr", owReadAddr, 32'h0);
    chk("rst_waddr", owWriteAddr, 32'h0);
    chk("rst_wdata", owWriteData, 32'h0);
    chk("rst_wstrb", {28'h0, owWstrb}, 32'h0);
    mem_clr = 1'b0;
    iwnRst  = 1'b1;

    // Word store then load back
    req(1'b1, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF, rd, flt, lat, ns, sb, wd);
    chk("sw_lat", lat, 2);
    chk("sw_nstrb", ns, 1);
    chk("sw_strb", {28'h0, sb}, 32'hF);
    chk("sw_wdata", wd, 32'hDEADBEEF);
    chk("sw_fault", {31'h0, flt}, 32'h0);
    chk("sw_rdata", rd, 32'h0);
    req(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, rd, flt, lat, ns, sb, wd);
    chk("lw_lat", lat, 2);
    chk("lw_nstrb", ns, 0);
    chk("lw_data", rd, 32'hDEADBEEF);
    req(1'b0, 2'b01, 1'b1, 32'd8, 32'h0, rd, flt, lat, ns, sb, wd);
    chk("lh_signed", rd, 32'hFFFFBEEF);

    // Byte store, signed and unsigned byte loads
    req(1'b1, 2'b00, 1'b0, 32'd4, 32'h12345680, rd, flt, lat, ns, sb, wd);
    chk("sb_strb", {28'h0, sb}, 32'h1);
    chk("sb_wdata", wd, 32'h00000080);
    req(1'b0, 2'b00, 1'b1, 32'd4, 32'h0, rd, flt, lat, ns, sb, wd);
    chk("lb_signed", rd, 32'hFFFFFF80);
    req(1'b0, 2'b00, 1'b0, 32'd4, 32'h0, rd, flt, lat, ns, sb, wd);
    chk("lb_unsigned", rd, 32'h00000080);

    // Misalignment faults; memory untouched
    req(1'b0, 2'b01, 1'b0, 32'd1, 32'h0, rd, flt, lat, ns, sb, wd);
    chk("lh_mis_fault", {31'h0, flt}, 32'h1);
    chk("lh_mis_lat", lat, 1);
    chk("lh_mis_data", rd, 32'h0);
    req(1'b1, 2'b10, 1'b0, 32'd6, 32'hFFFFFFFF, rd, flt, lat, ns, sb, wd);
    chk("sw_mis_fault", {31'h0, flt}, 32'h1);
    chk("sw_mis_lat", lat, 1);
    chk("sw_mis_nstrb", ns, 0);
    req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, rd, flt, lat, ns, sb, wd);
    chk("mem_unchanged", rd, 32'h00000080);

    // Bounds
    req(1'b1, 2'b10, 1'b0, 32'd172, 32'h11223344, rd, flt, lat, ns, sb, wd);
    chk("top_word_fault", {31'h0, flt}, 32'h0);
    chk("top_word_lat", lat, 2);
    req(1'b0, 2'b10, 1'b0, 32'd172, 32'h0, rd, flt, lat, ns, sb, wd);
    chk("top_word_data", rd, 32'h11223344);
    req(1'b0, 2'b01, 1'b0, 32'd174, 32'h0, rd, flt, lat, ns, sb, wd);
    chk("top_half_data", rd, 32'h00001122);
    req(1'b0, 2'b01, 1'b0, 32'd175, 32'h0, rd, flt, lat, ns, sb, wd);
    chk("half175_fault", {31'h0, flt}, 32'h1);
    req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, rd, flt, lat, ns, sb, wd);
    chk("wrap_fault", {31'h0, flt}, 32'h1);
    chk("wrap_lat", lat, 1);
    req(1'b0, 2'b11, 1'b0, 32'd0, 32'h0, rd, flt, lat, ns, sb, wd);
    chk("size11_fault", {31'h0, flt}, 32'h1);

    // Reset during the ACCESS cycle of a store
    @(posedge iwClk); #1;
    iwReqValid = 1'b1; iwReqWrite = 1'b1; iwReqSize = 2'b10; iwReqSigned = 1'b0;
    iwReqAddr = 32'd12; iwReqWdata = 32'hA5A5A5A5;
    @(posedge iwClk); #1;
    iwReqValid = 1'b0;
    chk("rstmid_strb_pre", {28'h0, owWstrb}, 32'hF);
    #1 iwnRst = 1'b0;
    #1;
    chk("rstmid_strb_zero", {28'h0, owWstrb}, 32'h0);
    chk("rstmid_ready", {31'h0, owReqReady}, 32'h1);
    rv = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge iwClk);
      if (owRespValid) rv++;
    end
    iwnRst = 1'b1;
    chk("rstmid_no_resp", rv, 0);
    req(1'b0, 2'b10, 1'b0, 32'd12, 32'h0, rd, flt, lat, ns, sb, wd);
    chk("rstmid_dropped", rd, 32'h0);

    // Back-to-back loads with valid held high
    @(posedge iwClk); #1;
    iwReqValid = 1'b1; iwReqWrite = 1'b0; iwReqSize = 2'b10; iwReqSigned = 1'b0;
    iwReqAddr = 32'd8;
    nacc = 0; nresp = 0; a1 = -1; a2 = -1;
    for (int c = 0; c < 9; c++) begin
      @(negedge iwClk);
      if (owReqReady) begin
        nacc++;
        if (nacc == 1) a1 = c;
        else if (nacc == 2) a2 = c;
      end
      if (owRespValid) begin
        nresp++;
        chk("b2b_data", owRespData, 32'hDEADBEEF);
      end
    end
    iwReqValid = 1'b0;
    chk("b2b_accepts", nacc, 3);
    chk("b2b_resps", nresp, 3);
    chk("b2b_spacing", a2 - a1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
